// File: rtl/node_mem_pkg.sv
// Shared definitions for the node memory subsystem: word geometry, the
// arbiter state encoding, requester indices and the fixed memory map.
package node_mem_pkg;

    // Word memory geometry: 2048 entries of 16-bit words.
    localparam int ADDR_W = 11;
    localparam int WORD_W = 16;

    // Arbiter states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Requester slots on the arbiter.
    localparam int WINNER_POLICY = 0;
    localparam int Q_UPDATE      = 1;
    localparam int PKT           = 2;
    localparam int CFG           = 3;

    // Memory map.
    localparam logic [ADDR_W-1:0] EPSILON_ADDR        = 11'h004;
    localparam logic [ADDR_W-1:0] BETTER_NBR_CNT_ADDR = 11'h68C;
    localparam logic [ADDR_W-1:0] BETTER_NBR_BASE     = 11'h668;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
// The arbiter takes the slave view; the requesters plus the memory
// together take the master view.
interface mem_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = node_mem_pkg::ADDR_W,
    parameter int WORD_W = node_mem_pkg::WORD_W
);

    // Requester side.
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*WORD_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_wr_en;
    logic [N_REQ-1:0]        gnt;
    logic [WORD_W-1:0]       rd_data;

    // Memory side.
    logic [ADDR_W-1:0]       mem_address;
    logic [WORD_W-1:0]       mem_data_out;
    logic                    mem_wr_en;
    logic [WORD_W-1:0]       mem_data_in;

    // Status and control.
    logic [N_REQ-1:0]        timeout_err;
    logic                    err_clr;
    logic                    busy;

    modport slave (
        input  req, req_addr, req_wdata, req_wr_en, mem_data_in, err_clr,
        output gnt, rd_data, mem_address, mem_data_out, mem_wr_en,
               timeout_err, busy
    );

    modport master (
        output req, req_addr, req_wdata, req_wr_en, mem_data_in, err_clr,
        input  gnt, rd_data, mem_address, mem_data_out, mem_wr_en,
               timeout_err, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first eligible requester starting at
// ptr and scanning upward with wrap-around. Purely combinational.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = node_mem_pkg::idx_width(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Walk the N positions in priority order; the first hit wins.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] pos;
        // NOTE: every variable gets a default before the search so that no
        // path through the loop leaves a value held, which would infer a latch.
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtraction wraps.
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            pos = sum[IDX_W-1:0];
            if (!found && eligible[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin lock arbiter for the node's single-port word memory.
// A requester holds req for a whole multi-access transaction; while it owns
// the lock its address, write data and write strobe drive the memory port.
// A hold-time watchdog revokes a stuck lock, flags the owner and keeps it
// out of arbitration until it drops req for at least one cycle.
module mem_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = node_mem_pkg::ADDR_W,
    parameter int WORD_W   = node_mem_pkg::WORD_W,
    parameter int MAX_HOLD = 64
) (
    input  logic                   clock,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus
);

    import node_mem_pkg::*;

    localparam int IDX_W  = idx_width(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    // Registered arbiter state.
    arb_state_t        state;
    logic [IDX_W-1:0]  own;
    logic [IDX_W-1:0]  rr_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  masked;
    logic [N_REQ-1:0]  timeout_q;

    // Arbitration and mux helpers.
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              owner_req;
    logic              hold_expired;
    logic [IDX_W-1:0]  next_ptr;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [WORD_W-1:0] wdata_arr [N_REQ];

    // Split the packed requester buses into per-requester words.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = bus.req_wdata[i*WORD_W +: WORD_W];
    end

    // A requester that timed out stays out until it drops req once.
    assign eligible = bus.req & ~masked;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    assign owner_req    = bus.req[own];
    assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD));
    assign next_ptr     = (own == IDX_W'(N_REQ - 1)) ? '0 : own + IDX_W'(1);

    // Arbitration FSM with owner bookkeeping, watchdog and sticky error flags.
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= '0;
            own       <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            masked    <= '0;
            timeout_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only; where
            // two assignments hit the same bit on one edge the later one wins,
            // which gives a timeout priority over err_clr below.
            masked <= masked & bus.req;
            if (bus.err_clr) begin
                timeout_q <= '0;
            end

            case (state)
                IDLE, TURN: begin
                    if (pick_found) begin
                        gnt_q    <= pick_onehot;
                        own      <= pick_idx;
                        hold_cnt <= HOLD_W'(1);
                        state    <= GRANT;
                    end else begin
                        gnt_q    <= '0;
                        state    <= IDLE;
                    end
                end

                GRANT: begin
                    if (!owner_req || hold_expired) begin
                        gnt_q  <= '0;
                        state  <= TURN;
                        rr_ptr <= next_ptr;
                        if (owner_req) begin
                            // Watchdog revocation of a lock still requested.
                            timeout_q[own] <= 1'b1;
                            masked[own]    <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    gnt_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port follows the registered owner; writes only while granted.
    assign bus.mem_address  = addr_arr[own];
    assign bus.mem_data_out = wdata_arr[own];
    assign bus.mem_wr_en    = (state == GRANT) && bus.req_wr_en[own];

    // Read data is broadcast; each requester qualifies it with its grant.
    assign bus.rd_data      = bus.mem_data_in;

    assign bus.gnt          = gnt_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.busy         = (state != IDLE);

    // Grant is never multi-hot, and a write strobe implies an active lock.
    a_gnt_onehot : assert property (@(posedge clock) disable iff (rst)
        $onehot0(gnt_q));
    a_wr_needs_gnt : assert property (@(posedge clock) disable iff (rst)
        bus.mem_wr_en |-> (gnt_q != '0));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a long
// randomized run compared against a cycle-level reference model.
module tb_mem_port_arbiter;

    import node_mem_pkg::*;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 64;

    logic clock = 1'b0;
    logic rst;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    mem_port_arbiter #(
        .N_REQ    (N_REQ),
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural single-port memory with a one-cycle read and a backdoor load.
    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [WORD_W-1:0] pre_data = '0;
    int                wr_cycles = 0;

    always @(posedge clock) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_address] <= bus.mem_data_out;
        end
        if (bus.mem_wr_en) begin
            wr_cycles <= wr_cycles + 1;
        end
        bus.mem_data_in <= mem[bus.mem_address];
    end

    // Reference model: owner as an int (-1 = none), cycles held, priority start.
    int               m_owner = -1;
    int               m_own   = 0;
    int               m_hold  = 0;
    int               m_ptr   = 0;
    bit               m_turn  = 1'b0;
    logic [N_REQ-1:0] m_masked = '0;
    logic [N_REQ-1:0] m_err    = '0;

    task automatic model_step();
        logic [N_REQ-1:0] r;
        logic [N_REQ-1:0] old_mask;
        int j;
        r        = bus.req;
        old_mask = m_masked;
        if (rst) begin
            m_owner = -1; m_own = 0; m_hold = 0; m_ptr = 0; m_turn = 1'b0;
            m_masked = '0; m_err = '0;
            return;
        end
        if (bus.err_clr) m_err = '0;
        m_masked = m_masked & r;
        if (m_owner >= 0) begin
            if (r[m_owner] && m_hold < MAX_HOLD) begin
                m_hold++;
            end else begin
                if (r[m_owner]) begin
                    m_err[m_owner]    = 1'b1;
                    m_masked[m_owner] = 1'b1;
                end
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
                m_turn  = 1'b1;
            end
        end else begin
            m_turn = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                j = (m_ptr + k) % N_REQ;
                if (m_owner < 0 && r[j] && !old_mask[j]) begin
                    m_owner = j;
                    m_own   = j;
                    m_hold  = 1;
                end
            end
        end
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_wr_en = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.err_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] a0;
        logic [WORD_W-1:0] d0;
        a0 = ADDR_W'($urandom_range(2047, 1));
        d0 = WORD_W'($urandom_range(65535, 1));
        do_reset();
        bus.req_addr[ADDR_W-1:0]  = a0;
        bus.req_wdata[WORD_W-1:0] = d0;
        bus.req_wr_en[0]          = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.mem_wr_en); end
        checks++; if (bus.timeout_err !== 4'b0000) begin failures++; $display("FAIL reset_err got=%b exp=0000", bus.timeout_err); end
        checks++; if (bus.mem_address !== a0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", bus.mem_address, a0); end
        checks++; if (bus.mem_data_out !== d0) begin failures++; $display("FAIL reset_wdata got=%h exp=%h", bus.mem_data_out, d0); end
        bus.req_wr_en[0] = 1'b0;
    endtask

    task automatic test_single_read();
        int start;
        do_reset();
        pre_en = 1'b1; pre_addr = EPSILON_ADDR; pre_data = 16'h0140;
        tick();
        pre_en = 1'b0;
        start = wr_cycles;
        bus.req_addr[PKT*ADDR_W +: ADDR_W] = EPSILON_ADDR;
        bus.req[PKT] = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL read_gnt got=%b exp=0100", bus.gnt); end
        checks++; if (bus.mem_address !== EPSILON_ADDR) begin failures++; $display("FAIL read_addr got=%h exp=%h", bus.mem_address, EPSILON_ADDR); end
        tick();
        checks++; if (bus.rd_data !== 16'h0140) begin failures++; $display("FAIL read_data got=%h exp=0140", bus.rd_data); end
        bus.req[PKT] = 1'b0;
        tick();
        checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin failures++; $display("FAIL read_turn gnt=%b busy=%b exp gnt=0000 busy=1", bus.gnt, bus.busy); end
        tick();
        checks++; if (wr_cycles !== start) begin failures++; $display("FAIL read_no_write got=%0d writes exp=0", wr_cycles - start); end
    endtask

    task automatic test_simultaneous();
        int exp_o;
        do_reset();
        bus.req = '1;
        tick();
        for (int n = 0; n < 5; n++) begin
            exp_o = n % N_REQ;
            checks++; if (bus.gnt !== onehot(exp_o)) begin failures++; $display("FAIL simul_order_%0d got=%b exp=%b", n, bus.gnt, onehot(exp_o)); end
            tick();
            tick();
            checks++; if (bus.gnt !== onehot(exp_o)) begin failures++; $display("FAIL simul_hold_%0d got=%b exp=%b", n, bus.gnt, onehot(exp_o)); end
            bus.req[exp_o] = 1'b0;
            tick();
            checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL simul_dead_%0d got=%b exp=0000", n, bus.gnt); end
            bus.req[exp_o] = 1'b1;
            tick();
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_write_release();
        int  start;
        bit  got;
        do_reset();
        start = wr_cycles;
        bus.req_addr[WINNER_POLICY*ADDR_W +: ADDR_W]  = EPSILON_ADDR;
        bus.req_wdata[WINNER_POLICY*WORD_W +: WORD_W] = 16'h0020;
        bus.req_wr_en[WINNER_POLICY] = 1'b1;
        bus.req[WINNER_POLICY]       = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0001 || bus.mem_wr_en !== 1'b1) begin failures++; $display("FAIL write_grant gnt=%b wr=%b exp gnt=0001 wr=1", bus.gnt, bus.mem_wr_en); end
        tick();
        bus.req_wr_en[WINNER_POLICY] = 1'b0;
        bus.req[WINNER_POLICY]       = 1'b0;
        tick();
        checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL write_turn gnt=%b busy=%b wr=%b exp 0000/1/0", bus.gnt, bus.busy, bus.mem_wr_en); end
        checks++; if (wr_cycles - start !== 1) begin failures++; $display("FAIL write_once got=%0d exp=1", wr_cycles - start); end
        bus.req_addr[Q_UPDATE*ADDR_W +: ADDR_W] = EPSILON_ADDR;
        bus.req[Q_UPDATE] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            got = bus.gnt[Q_UPDATE];
        end
        checks++; if (!got) begin failures++; $display("FAIL write_followup_gnt got=%b exp=0010 within 6 cycles", bus.gnt); end
        tick();
        checks++; if (bus.rd_data !== 16'h0020) begin failures++; $display("FAIL write_readback got=%h exp=0020", bus.rd_data); end
        bus.req[Q_UPDATE] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        int cnt1, cnt3, last1, first3;
        do_reset();
        bus.req[Q_UPDATE] = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL wd_first_gnt got=%b exp=0010", bus.gnt); end
        bus.req[CFG] = 1'b1;
        cnt1 = 1; cnt3 = 0; last1 = 0; first3 = -1;
        for (int i = 1; i < 100; i++) begin
            tick();
            if (bus.gnt[Q_UPDATE]) begin cnt1++; last1 = i; end
            if (bus.gnt[CFG]) begin
                if (first3 < 0) first3 = i;
                cnt3++;
                if (cnt3 == 2) bus.req[CFG] = 1'b0;
            end
        end
        checks++; if (cnt1 !== MAX_HOLD) begin failures++; $display("FAIL wd_hold_cycles got=%0d exp=%0d", cnt1, MAX_HOLD); end
        checks++; if (first3 !== last1 + 2) begin failures++; $display("FAIL wd_next_owner got_cycle=%0d exp_cycle=%0d", first3, last1 + 2); end
        checks++; if (bus.timeout_err !== 4'b0010) begin failures++; $display("FAIL wd_flag got=%b exp=0010", bus.timeout_err); end
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL wd_masked got=%b exp=0000", bus.gnt); end
        bus.req[Q_UPDATE] = 1'b0;
        tick();
        bus.req[Q_UPDATE] = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL wd_regrant got=%b exp=0010", bus.gnt); end
    endtask

    task automatic test_reset_mid_write();
        bus.req[Q_UPDATE] = 1'b0;
        tick();
        bus.req[CFG]       = 1'b1;
        bus.req_wr_en[CFG] = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b1000 || bus.mem_wr_en !== 1'b1) begin failures++; $display("FAIL rstw_pre gnt=%b wr=%b exp 1000/1", bus.gnt, bus.mem_wr_en); end
        checks++; if (bus.timeout_err !== 4'b0010) begin failures++; $display("FAIL rstw_pre_err got=%b exp=0010", bus.timeout_err); end
        rst = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rstw_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL rstw_wr got=%b exp=0", bus.mem_wr_en); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstw_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.timeout_err !== 4'b0000) begin failures++; $display("FAIL rstw_err got=%b exp=0000", bus.timeout_err); end
        rst = 1'b0;
        bus.req = '0;
        bus.req_wr_en = '0;
        tick();
    endtask

    task automatic test_err_clr_race();
        do_reset();
        bus.req[WINNER_POLICY] = 1'b1;
        tick();
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        checks++; if (bus.gnt !== 4'b0001 || bus.timeout_err !== 4'b0000) begin failures++; $display("FAIL race_pre gnt=%b err=%b exp 0001/0000", bus.gnt, bus.timeout_err); end
        bus.err_clr = 1'b1;
        tick();
        checks++; if (bus.timeout_err !== 4'b0001) begin failures++; $display("FAIL race_set_wins got=%b exp=0001", bus.timeout_err); end
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL race_revoked got=%b exp=0000", bus.gnt); end
        tick();
        checks++; if (bus.timeout_err !== 4'b0000) begin failures++; $display("FAIL race_clear got=%b exp=0000", bus.timeout_err); end
        bus.err_clr = 1'b0;
        bus.req = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N_REQ-1:0]  slow;
        logic [N_REQ-1:0]  e_gnt;
        logic [ADDR_W-1:0] e_addr;
        logic [WORD_W-1:0] e_data;
        logic              e_wr;
        logic              e_busy;
        int                lim;
        slow = '0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 400 == 0) slow = N_REQ'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                lim = slow[i] ? 150 : 6;
                if ($urandom_range(lim - 1, 0) == 0) bus.req[i] = ~bus.req[i];
                bus.req_wr_en[i] = 1'($urandom);
                bus.req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
                bus.req_wdata[i*WORD_W +: WORD_W] = WORD_W'($urandom);
            end
            bus.err_clr = ($urandom_range(15, 0) == 0);
            tick();
            e_gnt  = (m_owner >= 0) ? onehot(m_owner) : '0;
            e_busy = (m_owner >= 0) || m_turn;
            e_wr   = (m_owner >= 0) && bus.req_wr_en[m_own];
            e_addr = bus.req_addr[m_own*ADDR_W +: ADDR_W];
            e_data = bus.req_wdata[m_own*WORD_W +: WORD_W];
            checks++; if (bus.gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, e_gnt); end
            checks++; if (bus.busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, e_busy); end
            checks++; if (bus.mem_wr_en !== e_wr) begin failures++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", cyc, bus.mem_wr_en, e_wr); end
            checks++; if (bus.timeout_err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.timeout_err, m_err); end
            checks++; if (bus.mem_address !== e_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_address, e_addr); end
            checks++; if (bus.mem_data_out !== e_data) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_data_out, e_data); end
        end
        bus.req     = '0;
        bus.err_clr = 1'b0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_wr_en = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.err_clr   = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_release();
        test_watchdog();
        test_reset_mid_write();
        test_err_clr_race();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
